// File: rtl/stream_sorter_pkg.sv
// Shared definitions for the stream sorter: FSM state encoding and counter sizing.
package stream_sorter_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One extra bit over the index width so the counter can also track passes.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_sorter_compare_exchange.sv
// Unsigned compare-exchange lane: orders one pair as (Min, Max); ties pass straight through.
module compare_exchange #(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Min,
  output logic [W-1:0] Max
);

  logic swap;

  assign swap = (B < A);
  assign Min  = swap ? B : A;
  assign Max  = swap ? A : B;

endmodule

// File: rtl/stream_sorter.sv
// Frame sorter: loads DEPTH words, runs DEPTH odd-even transposition passes,
// then drains the frame in ascending order through a registered output stage.
module stream_sorter
  import stream_sorter_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 32,
  parameter int DEPTH           = 8
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic [INPUT_BIT_WIDTH-1:0] InData,
  input  logic                       InValid,
  output logic                       InReady,
  output logic [INPUT_BIT_WIDTH-1:0] OutData,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic                       OutLast,
  output logic                       Busy
);

  localparam int W  = INPUT_BIT_WIDTH;
  localparam int CW = cnt_width(DEPTH);
  localparam int IW = CW - 1;
  localparam int NP = DEPTH / 2;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx, nidx;
  logic                     odd;
  logic [DEPTH-1:0][W-1:0]  arr, nxt;
  logic [NP-1:0][W-1:0]     ca, cb, mn, mx;
  logic [W-1:0]             out_data;
  logic                     out_valid, out_last;

  assign idx  = cnt[IW-1:0];
  assign nidx = idx + 1'b1;
  assign odd  = cnt[0];

  // Each lane serves pair (2i,2i+1) on even passes and (2i+1,2i+2) on odd ones;
  // the top lane has no odd-pass partner and its result is discarded then.
  for (genvar i = 0; i < NP; i++) begin : g_ce
    if (i < NP - 1) begin : g_mid
      assign ca[i] = odd ? arr[2*i+1] : arr[2*i];
      assign cb[i] = odd ? arr[2*i+2] : arr[2*i+1];
    end else begin : g_end
      assign ca[i] = arr[2*i];
      assign cb[i] = arr[2*i+1];
    end
    compare_exchange #(.W(W)) u_ce (
      .A   (ca[i]),
      .B   (cb[i]),
      .Min (mn[i]),
      .Max (mx[i])
    );
  end

  always_comb begin
    nxt = arr;
    for (int i = 0; i < NP; i++) begin
      if (!odd) begin
        nxt[2*i]   = mn[i];
        nxt[2*i+1] = mx[i];
      end else if (i < NP - 1) begin
        nxt[2*i+1]             = mn[i];
        nxt[(2*i+2) % DEPTH]   = mx[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= LOAD;
      cnt       <= '0;
      arr       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: if (InValid) begin
          arr[idx] <= InData;
          if (cnt == LAST) begin
            state <= SORT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SORT: begin
          arr <= nxt;
          if (cnt == LAST) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          // First DRAIN cycle primes the output register; afterwards each
          // handshake advances the index and prefetches the next word.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= arr[idx];
            out_last  <= (cnt == LAST);
          end else if (OutReady) begin
            if (out_last) begin
              state     <= LOAD;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              cnt      <= cnt + 1'b1;
              out_data <= arr[nidx];
              out_last <= (cnt == LAST - 1'b1);
            end
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign InReady  = (state == LOAD);
  assign Busy     = (state != LOAD);
  assign OutData  = out_data;
  assign OutValid = out_valid;
  assign OutLast  = out_last;

endmodule

// File: tb/tb_stream_sorter.sv
// Directed + randomized bench for stream_sorter (DEPTH=4, 32-bit) against a queue-sort model.
module tb_stream_sorter;

  localparam int W = 32;
  localparam int D = 4;

  typedef logic [W-1:0] frame_t [D];

  logic         Clk = 1'b0;
  logic         nReset = 1'b0;
  logic [W-1:0] InData = '0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [W-1:0] OutData;
  logic         OutValid;
  logic         OutReady = 1'b0;
  logic         OutLast;
  logic         Busy;

  int checks   = 0;
  int failures = 0;

  stream_sorter #(.INPUT_BIT_WIDTH(W), .DEPTH(D)) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .InData   (InData),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutLast  (OutLast),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the frame's words in ascending unsigned order.
  function automatic frame_t model(input frame_t f);
    logic [W-1:0] q[$];
    frame_t r;
    foreach (f[i]) q.push_back(f[i]);
    q.sort();
    foreach (r[i]) r[i] = q[i];
    return r;
  endfunction

  // Presents n words back to back; for a full frame, measures handshake-to-OutValid latency.
  task automatic load_frame(input frame_t f, input int n, input bit junk, input string tag);
    int lat;
    OutReady = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check($sformatf("%s_inready%0d", tag, i), InReady, 1);
      InValid = 1'b1;
      InData  = f[i];
    end
    @(negedge Clk);
    InValid = junk;
    InData  = junk ? 32'd11 : '0;
    if (n == D) begin
      check({tag, "_busy_sort"}, Busy, 1);
      check({tag, "_inready_sort"}, InReady, 0);
      lat = 0;
      while (!OutValid && lat < 50) begin
        @(negedge Clk);
        lat++;
      end
      check({tag, "_latency"}, lat, D + 1);
    end
  endtask

  task automatic drain(input frame_t exp_w, input bit rnd, input bit junk, input string tag);
    int k = 0;
    int cyc = 0;
    bit hold = 0;
    logic [W-1:0] pd = '0;
    logic pl = 1'b0;
    while (k < D && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (junk) begin
        InValid = 1'b1;
        InData  = 32'd11;
      end
      if (hold) begin
        check({tag, "_hold_valid"}, OutValid, 1);
        check({tag, "_hold_data"}, OutData, pd);
        check({tag, "_hold_last"}, OutLast, pl);
      end
      OutReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (OutValid) begin
        check({tag, "_inready_drain"}, InReady, 0);
        if (OutReady) begin
          check($sformatf("%s_data%0d", tag, k), OutData, exp_w[k]);
          check($sformatf("%s_last%0d", tag, k), OutLast, (k == D - 1));
          k++;
          hold = 0;
        end else begin
          hold = 1;
          pd   = OutData;
          pl   = OutLast;
        end
      end
    end
    check({tag, "_word_count"}, k, D);
    @(negedge Clk);
    InValid  = 1'b0;
    OutReady = 1'b0;
    check({tag, "_busy_after"}, Busy, 0);
    check({tag, "_inready_after"}, InReady, 1);
    check({tag, "_outvalid_after"}, OutValid, 0);
  endtask

  initial begin
    frame_t f;

    #1;
    check("rst_inready", InReady, 1);
    check("rst_outvalid", OutValid, 0);
    check("rst_outlast", OutLast, 0);
    check("rst_busy", Busy, 0);
    check("rst_outdata", OutData, 0);
    @(negedge Clk);
    nReset = 1'b1;

    f = '{32'd7, 32'd3, 32'd9, 32'd1};
    load_frame(f, D, 0, "basic");
    drain(model(f), 0, 0, "basic");

    f = '{32'd5, 32'd5, 32'd5, 32'd5};
    load_frame(f, D, 0, "equal");
    drain(model(f), 0, 0, "equal");

    f = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1};
    load_frame(f, D, 0, "unsigned");
    drain(model(f), 0, 0, "unsigned");

    f = '{32'd4, 32'd3, 32'd2, 32'd1};
    load_frame(f, D, 0, "stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("stall_valid", OutValid, 1);
      check("stall_data", OutData, 1);
      check("stall_inready", InReady, 0);
    end
    drain(model(f), 1, 0, "stall");

    f = '{32'd8, 32'd6, 32'd0, 32'd0};
    load_frame(f, 2, 0, "partial");
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    check("midrst_inready", InReady, 1);
    check("midrst_outvalid", OutValid, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_outdata", OutData, 0);
    #1;
    nReset = 1'b1;
    f = '{32'd2, 32'd9, 32'd4, 32'd1};
    load_frame(f, D, 0, "postrst");
    drain(model(f), 0, 0, "postrst");

    f = '{32'd7, 32'd3, 32'd9, 32'd1};
    load_frame(f, D, 1, "junk");
    drain(model(f), 0, 1, "junk");
    f = '{32'd20, 32'd15, 32'd30, 32'd12};
    load_frame(f, D, 0, "afterjunk");
    drain(model(f), 0, 0, "afterjunk");

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < D; i++)
        f[i] = n[0] ? 32'($urandom_range(0, 7)) : 32'($urandom);
      load_frame(f, D, n[1], $sformatf("rand%0d", n));
      drain(model(f), 1, n[1], $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
